// File: rtl/seq_divider_pkg.sv
// Shared types and default sizing for the sequential restoring divider.
// Optional SEQ_DIVIDER_EARLY_EXIT_EN build skips leading-zero iterations.
package div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;
    localparam int DIV_CW = $clog2(DIV_DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold the full dividend width.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done request and result bundle between a requester and seq_divider.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_zero
    );

endinterface

// File: rtl/seq_divider_lzc.sv
// Leading-zero count of the dividend; used only by the early-exit build
// (SEQ_DIVIDER_EARLY_EXIT_EN) to size and pre-align the iteration.
module div_lzc
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    localparam int CW = cnt_width(DW)
) (
    input  logic [DW-1:0] value,
    output logic [CW-1:0] count
);

    // any_above[i] is set when some bit at or above position i is set.
    logic [DW:0] any_above;

    assign any_above[DW] = 1'b0;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_scan
            assign any_above[gi] = any_above[gi+1] | value[gi];
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < DW; i++) begin
            count = count + CW'(!any_above[i]);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_EARLY_EXIT_EN to skip the dividend's leading zeros.
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CW = cnt_width(DW);

    state_t        state_reg;
    logic [DW-1:0] dq_reg;
    logic [VW-1:0] rem_reg;
    logic [VW-1:0] dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [DW-1:0] quo_reg;
    logic [VW-1:0] rmd_reg;
    logic          dz_reg;

    logic [DW-1:0] load_dq;
    logic [CW-1:0] load_cnt;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    logic [CW-1:0] lead_zeros;

    div_lzc #(.DW(DW)) u_lzc (
        .value (bus.dividend),
        .count (lead_zeros)
    );

    // A zero dividend still runs one iteration so the result path is shared.
    assign load_dq  = bus.dividend << lead_zeros;
    assign load_cnt = (lead_zeros == CW'(DW)) ? CW'(1) : CW'(DW) - lead_zeros;
`else
    assign load_dq  = bus.dividend;
    assign load_cnt = CW'(DW);
`endif

    // The shifted partial remainder needs VW+1 bits; after restoring it fits in VW.
    logic [VW:0]   rem_shift;
    logic          rem_ge;
    logic [VW-1:0] rem_next;
    logic [DW-1:0] dq_next;

    always_comb begin
        rem_shift = {rem_reg, dq_reg[DW-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_reg});
        rem_next  = rem_ge ? VW'(rem_shift - {1'b0, dvs_reg}) : rem_shift[VW-1:0];
        dq_next   = {dq_reg[DW-2:0], rem_ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            dq_reg    <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            quo_reg   <= '0;
            rmd_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvs_reg <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            quo_reg   <= '1;
                            rmd_reg   <= '0;
                            dz_reg    <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                            dq_reg    <= load_dq;
                            rem_reg   <= '0;
                            cnt_reg   <= load_cnt;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    dq_reg  <= dq_next;
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        quo_reg   <= dq_next;
                        rmd_reg   <= rem_next;
                        dz_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quo_reg;
    assign bus.remainder = rmd_reg;
    assign bus.div_zero  = dz_reg;

endmodule
